// File: rtl/des_decrypt_key_stream.sv
`default_nettype none
// ============================================================================
// Module   : des_decrypt_key_stream
// Purpose  : DES decryption key schedule; streams K16..K1 over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module des_decrypt_key_stream (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:64] keyIn,
    input  logic        subkey_ready,
    output logic [1:48] subkey,
    output logic        subkey_valid,
    output logic [4:0]  key_num,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CALC = 3'd2,
        S_OUT  = 3'd3,
        S_ROT  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam int c_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int c_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [1:56] f_pc1(input logic [1:64] k);
        logic [1:56] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[i+1] = k[c_PC1[i]];
        end
        return r;
    endfunction

    function automatic logic [1:48] f_pc2(input logic [1:56] cd);
        logic [1:48] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[i+1] = cd[c_PC2[i]];
        end
        return r;
    endfunction

    state_t      r_state;
    logic [1:64] r_key;
    logic [1:28] r_c;
    logic [1:28] r_d;
    logic        r_start_prev;

    logic        w_start_edge;
    logic        w_handshake;
    logic        w_single_shift;
    logic [1:56] w_pc1;
    logic [1:48] w_pc2;

    assign w_start_edge   = start & ~r_start_prev;
    assign w_handshake    = subkey_valid & subkey_ready;
    assign w_single_shift = (key_num == 5'd1) | (key_num == 5'd2) |
                            (key_num == 5'd9) | (key_num == 5'd16);
    assign w_pc1          = f_pc1(r_key);
    assign w_pc2          = f_pc2({r_c, r_d});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_key        <= '0;
            r_c          <= '0;
            r_d          <= '0;
            r_start_prev <= 1'b0;
            subkey       <= '0;
            subkey_valid <= 1'b0;
            key_num      <= 5'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            r_start_prev <= start;
            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        r_key   <= keyIn;
                        busy    <= 1'b1;
                        key_num <= 5'd16;
                        r_state <= S_LOAD;
                    end
                end
                // C16/D16 equal C0/D0, so K16 needs no rotation
                S_LOAD: begin
                    r_c     <= w_pc1[1:28];
                    r_d     <= w_pc1[29:56];
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    subkey       <= w_pc2;
                    subkey_valid <= 1'b1;
                    r_state      <= S_OUT;
                end
                S_OUT: begin
                    if (w_handshake) begin
                        subkey_valid <= 1'b0;
                        if (key_num == 5'd1) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_ROT;
                        end
                    end
                end
                // Undo the forward left shift of round key_num: rotate right
                S_ROT: begin
                    if (w_single_shift) begin
                        r_c <= {r_c[28], r_c[1:27]};
                        r_d <= {r_d[28], r_d[1:27]};
                    end else begin
                        r_c <= {r_c[27:28], r_c[1:26]};
                        r_d <= {r_d[27:28], r_d[1:26]};
                    end
                    key_num <= key_num - 5'd1;
                    r_state <= S_CALC;
                end
                S_DONE: begin
                    if (!start) begin
                        done    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_des_decrypt_key_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_decrypt_key_stream
// Purpose  : Self-checking bench against a forward DES key-schedule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_des_decrypt_key_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:64] keyIn = '0;
    logic        subkey_ready = 1'b0;
    logic [1:48] subkey;
    logic        subkey_valid;
    logic [4:0]  key_num;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [1:48] ref_k [1:16];

    int pc1_t [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    int pc2_t [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam logic [1:64] c_KNOWN = 64'h133457799BBCDFF1;

    always #5 clk = ~clk;

    des_decrypt_key_stream dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .keyIn        (keyIn),
        .subkey_ready (subkey_ready),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .key_num      (key_num),
        .busy         (busy),
        .done         (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Forward schedule: round r uses C0/D0 left-rotated by the cumulative shift.
    task automatic ref_gen(input logic [1:64] key);
        logic [1:28] c0;
        logic [1:28] d0;
        logic [1:56] cd;
        int tot;
        for (int i = 0; i < 28; i++) begin
            c0[i+1] = key[pc1_t[i]];
            d0[i+1] = key[pc1_t[i+28]];
        end
        tot = 0;
        for (int r = 1; r <= 16; r++) begin
            tot += (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
            for (int j = 0; j < 28; j++) begin
                cd[j+1]  = c0[((j + tot) % 28) + 1];
                cd[j+29] = d0[((j + tot) % 28) + 1];
            end
            for (int i = 0; i < 48; i++) begin
                ref_k[r][i+1] = cd[pc2_t[i]];
            end
        end
    endtask

    task automatic stream(input logic [1:64] key, input int max_stall,
                          input int pulse_at, input int stop_at);
        logic [1:48] hold_k;
        logic [4:0]  hold_n;
        int n;
        int stall;
        ref_gen(key);
        @(negedge clk);
        keyIn        = key;
        start        = 1'b1;
        subkey_ready = (max_stall == 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) keyIn = {$urandom, $urandom};
        end while (!subkey_valid && n < 10);
        chk("first_latency", n, 3);
        chk("busy_running", busy, 1);
        for (int p = 1; p <= 16; p++) begin
            chk("valid", subkey_valid, 1);
            chk("done_early", done, 0);
            chk("key_num", key_num, 17 - p);
            chk("subkey", subkey, ref_k[17-p]);
            if (key == c_KNOWN && (p == 1 || p == 15 || p == 16))
                chk("known_vec", subkey, (p == 1)  ? 48'hCB3D8B0E17F5 :
                                         (p == 15) ? 48'h79AED9DBC9E5 : 48'h1B02EFFC7072);
            if (p == stop_at) return;
            hold_k = subkey;
            hold_n = key_num;
            if (p == pulse_at) begin
                subkey_ready = 1'b0;
                start = 1'b0;
                @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                chk("pulse_hold", {subkey_valid, key_num, subkey}, {1'b1, hold_n, hold_k});
            end
            stall = (max_stall > 0) ? $urandom_range(0, max_stall) : 0;
            for (int s = 0; s < stall; s++) begin
                subkey_ready = 1'b0;
                @(negedge clk);
                chk("stall_hold", {subkey_valid, key_num, subkey}, {1'b1, hold_n, hold_k});
            end
            subkey_ready = 1'b1;
            @(negedge clk);
            subkey_ready = (max_stall == 0);
            if (p < 16) begin
                n = 1;
                while (!subkey_valid && n < 12) begin
                    @(negedge clk);
                    n++;
                end
                if (max_stall == 0) chk("gap", n, 3);
            end
        end
        chk("done_set", done, 1);
        chk("busy_clear", busy, 0);
        chk("valid_clear", subkey_valid, 0);
        repeat (3) @(negedge clk);
        chk("done_held", done, 1);
        start = 1'b0;
        @(negedge clk);
        chk("done_drop", done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", subkey_valid, 0);
        chk("rst_subkey", subkey, 0);
        chk("rst_key_num", key_num, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_valid", subkey_valid, 0);

        stream(c_KNOWN, 0, 0, 0);
        stream(c_KNOWN, 7, 0, 0);
        stream(64'h0, 0, 0, 0);
        for (int k = 0; k < 4; k++) stream({$urandom, $urandom}, (k % 2) ? 7 : 0, 0, 0);
        stream({$urandom, $urandom}, 3, 7, 0);

        // Abandon a stream mid-way with reset while presenting K7
        stream({$urandom, $urandom}, 2, 0, 10);
        @(negedge clk);
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", subkey_valid, 0);
        chk("async_subkey", subkey, 0);
        chk("async_key_num", key_num, 0);
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_valid", subkey_valid, 0);
        chk("post_rst_busy", busy, 0);
        stream(c_KNOWN, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/des_decrypt_key_stream.md
Name: des_decrypt_key_stream

Overview:
- Decryption-side DES key schedule.
- On a start request it takes the 64-bit key and streams all sixteen 48-bit round subkeys in reverse order (K16 first, K1 last).
- It regenerates C/D by right-rotating from C0/D0 rather than left-rotating per key ID.
- It feeds the DES round datapath when running in decrypt mode, one subkey per valid/ready handshake.

Parameters:
- None. Shift schedule, PC-1 and PC-2 tables are fixed DES constants.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  level request; rising edge (start && !start_prev) begins a key stream
- keyIn  input  [1:64]  64-bit DES key, MSB-first bit numbering; sampled on the start-edge cycle only
- subkey_ready  input  1  downstream accepts subkey this cycle when high with subkey_valid
- subkey  output  [1:48]  current round subkey (registered)
- subkey_valid  output  1  subkey/key_num hold valid data
- key_num  output  [4:0]  DES index of subkey presented (16 down to 1)
- busy  output  1  high from start edge until done asserts
- done  output  1  all 16 subkeys accepted; held until start deasserts

Behaviour:
- Reset (async, any state, including mid-stream) sets:
  - state=IDLE
  - subkey=0, subkey_valid=0, key_num=0, busy=0, done=0
  - C=D=0, start_prev=0
- An in-flight stream is abandoned with no partial completion.
- start_prev registers start every cycle; only the rising edge matters.
- States are IDLE, LOAD, CALC, OUT, ROT, DONE.
- IDLE:
  - On start edge, sample keyIn, go to LOAD.
  - busy=1, key_num<=16.
  - No start edge: stay in IDLE.
- LOAD:
  - {C,D} <= PC1(sampled key); C = PC1 bits 1..28, D = PC1 bits 29..56. Go to CALC.
  - C16=C0 and D16=D0 (total rotation is 28), so no rotation precedes K16.
- CALC: subkey <= PC2({C,D}). Go to OUT.
- OUT:
  - subkey_valid=1; subkey and key_num stay stable until handshake (subkey_valid && subkey_ready).
  - On handshake: subkey_valid<=0.
  - If key_num==1, go to DONE.
  - Otherwise go to ROT.
- ROT:
  - Rotate C and D right by shift[key_num], using the pre-decrement value, where shift = 1 for key_num in {1,2,9,16}, else 2.
  - Then key_num <= key_num-1, go to CALC.
  - Rotation is cyclic within each 28-bit half; C bit 28 wraps to bit 1.
- DONE:
  - done=1, busy=0.
  - Stay while start=1; when start=0, done<=0 and go to IDLE.
- Timing:
  - Start-edge cycle N (the IDLE->LOAD transition), then LOAD at N+1 and CALC at N+2.
  - First subkey_valid at N+3.
  - After each handshake, next subkey_valid rises 3 cycles later (ROT, CALC, OUT).
  - Best case 16 subkeys: K16 at N+3, K(16-i) valid at N+3+3i, done from N+49.
- Start edge while busy or in DONE is ignored. keyIn changes after sampling have no effect.
- subkey_ready high outside OUT has no effect.
- Backpressure holds OUT for any number of cycles, with no data change.
- Rotation total check: right rotations after K16 sum to 27 per half. K1 equals PC2 of C0/D0 rotated left by 1.

Test Plan:
- Reset, then key 0x133457799BBCDFF1, start edge, subkey_ready tied 1:
  - subkey_valid rises 3 cycles after the start-edge cycle.
  - First subkey 0xCB3D8B0E17F5, key_num=16.
  - Last subkey 0x1B02EFFC7072, key_num=1.
  - Second-to-last subkey 0x79AED9DBC9E5, key_num=2.
  - done after exactly 16 handshakes.
- Same key, random subkey_ready stalls 0-7 cycles: identical 16-value sequence; subkey/key_num stable while valid && !ready; no duplicates or drops.
- Cross-check against the forward key generator for all 16 IDs with random keys:
  - Stream position p carries forward subkey of ID 17-p.
  - Key 0x0000000000000000 gives all-zero subkeys.
- Second start edge pulsed at K10 during the stream: ignored, stream completes unchanged.
- done held while start=1; new stream only after start low then high.
- rst_n asserted low during OUT at key_num=7:
  - All outputs 0 immediately (async).
  - After release, no output until a new start edge.
  - Next stream restarts at key_num=16.
